// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled start-bit validation, configurable frame
// format and a show-ahead receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int unsigned DIV        = 78,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          clear_err
);

  localparam int unsigned DivW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SubW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(DIV - 1);
  localparam logic [SubW-1:0] SubHalf  = SubW'(OVERSAMPLE / 2 - 1);
  localparam logic [SubW-1:0] SubFull  = SubW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DivW-1:0]      div_q, div_d;
  logic                 tick;
  state_e               state_q, state_d;
  logic [SubW-1:0]      sub_q, sub_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 sample;
  logic                 push_req, frame_set, parity_set;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 pop, push, full, ovf_set;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overflow_q, overflow_d;

  // Two-flop synchroniser; idles high so reset looks like a quiet line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  // Free-running oversample tick divider.
  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  // Mid-bit sampling point: half a bit after the start edge, then whole bits.
  always_comb begin
    sample = tick && ((state_q == StStart) ? (sub_q == SubHalf) : (sub_q == SubFull));
  end

  // FSM state and frame datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sub_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Next-state logic; everything advances only on tick cycles.
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    if (tick) begin
      if (state_q inside {StStart, StData, StParity, StStop}) begin
        sub_d = sample ? '0 : sub_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d = StStart;
            sub_d   = '0;
          end
        end
        StStart: begin
          if (sample) begin
            bit_d     = '0;
            par_bad_d = 1'b0;
            state_d   = rx_s ? StIdle : StData;
          end
        end
        StData: begin
          if (sample) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == DataLast) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (sample) begin
            // Odd parity wants the XOR of data and parity bit to be 1.
            par_bad_d = (PARITY == 1) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
            state_d   = StStop;
          end
        end
        StStop: begin
          if (sample) begin
            if (!rx_s)                  state_d = StBreak;
            else if (bit_q == StopLast) state_d = StIdle;
            else                        bit_d   = bit_q + 1'b1;
          end
        end
        StBreak: begin
          if (rx_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame outcome strobes, all on the cycle of a stop-bit sample.
  always_comb begin
    push_req   = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    if (state_q == StStop && sample) begin
      if (!rx_s) begin
        frame_set = 1'b1;
      end else if (bit_q == StopLast) begin
        if (par_bad_q) parity_set = 1'b1;
        else           push_req   = 1'b1;
      end
    end
  end

  // FIFO control; a full FIFO still accepts a push if it is popped that cycle.
  always_comb begin
    pop      = rd_en && rd_valid;
    full     = (count_q == CntFull);
    push     = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only visible through rd_valid-gated rd_data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  // Sticky flags: a new set wins over a simultaneous clear.
  always_comb begin
    frame_err_d  = frame_set  | (frame_err_q  & ~clear_err);
    parity_err_d = parity_set | (parity_err_q & ~clear_err);
    overflow_d   = ovf_set    | (overflow_q   & ~clear_err);
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with oversampled start-bit validation, configurable frame format (data bits, parity, stop bits) and a show-ahead receive FIFO.
- Successor to the fixed 8N1 receive path: replaces the externally divided UART clock with an internal tick divider on the system clock.
- Adds error flags and buffering so downstream logic (hex conversion, display shift, echo queue) consumes bytes with a read strobe instead of a completion pulse.

Parameters:
DIV, 78, system clocks per oversample tick (48 MHz / (38400*16) ≈ 78); must be ≥1
OVERSAMPLE, 16, ticks per bit period; even, ≥4
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, entries; power of two, ≥2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx  in  1  serial line, idle high, asynchronous to clk
rd_en  in  1  pop request; ignored when FIFO empty
rd_data  out  DATA_BITS  FIFO head (show-ahead); valid while rd_valid=1
rd_valid  out  1  FIFO not empty
count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
overflow  out  1  sticky: a good frame arrived while FIFO was full
clear_err  in  1  clears all three sticky flags

Behaviour:
- Reset: all state machines to IDLE, tick counter 0, synchroniser flops 1, FIFO pointers 0, rd_valid=0, count=0, rd_data=0, all error flags 0.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value (2-clk input latency).
- Tick divider counts 0..DIV-1 and free-runs; the tick pulse is one clk wide when the count = DIV-1. All FSM transitions occur only on tick cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when the line is sampled 0 on a tick, go to START with the sub-counter at 0.
- START: after OVERSAMPLE/2 ticks (mid-bit), if the line is 1 treat it as a glitch and return to IDLE; otherwise go to DATA.
- DATA: sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples. Then go to PARITY if PARITY≠0, else to STOP.
- PARITY: one sample. Odd: XOR of data and parity bit must be 1. Even: that XOR must be 0.
- STOP: STOP_BITS samples spaced OVERSAMPLE ticks apart.
  - Any stop sample 0: set frame_err, discard the byte, go to BREAK.
  - Otherwise, if a parity error occurred, set parity_err, discard the byte, go to IDLE.
  - Otherwise push the byte and go to IDLE immediately after the last stop sample (mid-bit), so back-to-back frames are caught.
- BREAK: wait until the line is sampled 1, then go to IDLE. A held-low line yields exactly one frame_err.
- Push: occurs on the clk cycle of the final stop sample.
  - If the FIFO is full and rd_en=0 in that cycle: drop the byte, set overflow.
  - If the FIFO is full and rd_en=1 in the same cycle: pop and push both proceed, count unchanged, no overflow.
- Pop: rd_en=1 and rd_valid=1 advances the read pointer. The new head appears on rd_data the next cycle. rd_en when empty has no effect.
- Simultaneous push and pop with count=0: push only (no show-ahead bypass); rd_valid rises the next cycle.
- count increments on push-only, decrements on pop-only, and is unchanged on both.
- Sticky flags: clear_err clears them on the next edge. If clear_err and a new error set occur in the same cycle, the set wins.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied, and a receiver brought out of reset with rx low waits in IDLE for a falling sample (goes straight to START only if the synchronised value is 0 at the first tick).
- Latency: a byte's stop-bit mid-sample to rd_valid=1 is 1 clk.

Test Plan:
1. DIV=2, OVERSAMPLE=16, 8N1: send 0x41 then 0x7E back-to-back → rd_valid=1 after first frame, count=2, rd_data=0x41; pulse rd_en → rd_data=0x7E, count=1; no error flags.
2. 0.25-bit low glitch (8 clk) on idle line → FSM returns to IDLE, count=0, no flags.
3. PARITY=2: send 0x03 with parity bit 1 → byte discarded, parity_err=1, count=0; pulse clear_err → parity_err=0; then send 0x03 with parity 0 → count=1, rd_data=0x03.
4. Hold rx low for 3 frame times → exactly one frame_err, count=0; release rx and send 0x55 → received correctly.
5. FIFO_DEPTH=4: send 5 bytes 0x10..0x14 with no reads → count=4, overflow=1, pops yield 0x10..0x13. Repeat with rd_en asserted on the 5th push cycle → no overflow, count stays 4.
6. Assert rst halfway through the data bits of 0xA5 with 2 bytes queued → all outputs at reset values; the next full frame 0x5A is received alone, count=1.
